// File: rtl/arb_pkg.sv
// Shared types and helpers for the credit-based weighted round-robin arbiter
// and its reusable rotating-priority picker.
package arb_pkg;

   localparam int DEF_NUM_REQ  = 8;
   localparam int DEF_WEIGHT_W = 4;

   typedef logic [DEF_WEIGHT_W-1:0] weight_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // OR-reduction of set-bit positions; exact for a one-hot input, 0 for zero.
   function automatic int onehot2idx(input logic [31:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/wrr_credit_arbiter_if.sv
// Request/grant/ack handshake bundle between the requesters, the shared target
// and the credit WRR arbiter (arbiter side uses the slave modport).
interface wrr_credit_arbiter_if
   import arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) ();

   logic [NUM_REQ-1:0]         req;
   logic                       ack;
   logic [NUM_REQ-1:0]         grant;
   logic                       grant_valid;
   logic [$clog2(NUM_REQ)-1:0] grant_idx;

   modport master (
      output req,
      output ack,
      input  grant,
      input  grant_valid,
      input  grant_idx
   );

   modport slave (
      input  req,
      input  ack,
      output grant,
      output grant_valid,
      output grant_idx
   );

endinterface

// File: rtl/wrr_rr_picker.sv
// Combinational rotating-priority picker: first set bit of vec at or above ptr,
// wrapping modulo N, returned as one-hot plus binary index.
module wrr_rr_picker
   import arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ
) (
   input  logic [N-1:0]         vec,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int IW = $clog2(N);

   function automatic int wrap_pos(input int p, input int k);
      int s;
      s = p + k;
      return (s >= N) ? (s - N) : s;
   endfunction

   always_comb begin
      onehot = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && vec[wrap_pos(int'(ptr), k)]) begin
            found                          = 1'b1;
            onehot[wrap_pos(int'(ptr), k)] = 1'b1;
         end
      end
   end

   assign idx = IW'(onehot2idx(32'(onehot)));

endmodule

// File: rtl/wrr_credit_arbiter.sv
// Credit-counter weighted round-robin arbiter with registered one-hot grant and
// grant/ack handshake. Define WRR_CREDIT_ARBITER_STATS_EN to add grant_cnt.
module wrr_credit_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int WEIGHT_W     = DEF_WEIGHT_W,
   parameter int RESET_WEIGHT = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0][WEIGHT_W-1:0] weight,
   input  logic                             weight_load,
`ifdef WRR_CREDIT_ARBITER_STATS_EN
   output logic [NUM_REQ-1:0][15:0]         grant_cnt,
`endif
   wrr_credit_arbiter_if.slave              bus
);

   localparam int IW = $clog2(NUM_REQ);

   typedef logic [WEIGHT_W-1:0] credit_t;
   localparam credit_t RST_W = credit_t'(RESET_WEIGHT);

   arb_state_e            state, state_n;
   credit_t [NUM_REQ-1:0] weight_q, weight_n;
   credit_t [NUM_REQ-1:0] credit, credit_b, credit_n;
   logic [IW-1:0]         ptr, ptr_b;
   logic [NUM_REQ-1:0]    grant_q, grant_n;
   logic                  gv_q, gv_n;
   logic [IW-1:0]         gidx_q, gidx_n;

   logic                  accept;
   logic [NUM_REQ-1:0]    live_n, elig_n, cand;
   logic [NUM_REQ-1:0]    pick_oh;
   logic [IW-1:0]         pick_idx;
   logic                  pick_found;

   assign accept = (state == GRANT) && bus.ack;

   // Post-transfer view of weights, credits and pointer; the next pick sees this.
   always_comb begin
      weight_n = weight_load ? weight : weight_q;
      credit_b = credit;
      ptr_b    = ptr;
      if (weight_load) begin
         credit_b = weight;
      end else if (accept && (credit[gidx_q] != '0)) begin
         credit_b[gidx_q] = credit[gidx_q] - credit_t'(1);
         if (credit_b[gidx_q] == '0)
            ptr_b = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
         else
            ptr_b = gidx_q;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         live_n[i] = bus.req[i] && (weight_n[i] != '0);
         elig_n[i] = live_n[i] && (credit_b[i] != '0);
      end
      cand = (elig_n != '0) ? elig_n : live_n;
   end

   wrr_rr_picker #(
      .N (NUM_REQ)
   ) u_picker (
      .vec    (cand),
      .ptr    (ptr_b),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   always_comb begin
      logic take_pick;
      logic hold;
      take_pick = 1'b0;
      hold      = 1'b0;
      state_n   = IDLE;
      grant_n   = '0;
      gv_n      = 1'b0;
      gidx_n    = '0;
      credit_n  = credit_b;
      case (state)
         IDLE:    take_pick = pick_found;
         GRANT: begin
            if (!bus.ack && live_n[gidx_q]) hold = 1'b1;
            else                            take_pick = pick_found;
         end
         default: ;
      endcase
      if (hold) begin
         state_n = GRANT;
         grant_n = grant_q;
         gv_n    = 1'b1;
         gidx_n  = gidx_q;
      end else if (take_pick) begin
         state_n = GRANT;
         grant_n = pick_oh;
         gv_n    = 1'b1;
         gidx_n  = pick_idx;
         // Round exhausted: refill from weights in the same cycle, no bubble.
         if (elig_n == '0) credit_n = weight_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         grant_q  <= '0;
         gv_q     <= 1'b0;
         gidx_q   <= '0;
         weight_q <= {NUM_REQ{RST_W}};
         credit   <= {NUM_REQ{RST_W}};
      end else begin
         state    <= state_n;
         ptr      <= ptr_b;
         grant_q  <= grant_n;
         gv_q     <= gv_n;
         gidx_q   <= gidx_n;
         weight_q <= weight_n;
         credit   <= credit_n;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = gv_q;
   assign bus.grant_idx   = gidx_q;

`ifdef WRR_CREDIT_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_cnt <= '0;
      end else if (weight_load) begin
         grant_cnt <= '0;
      end else if (accept && (grant_cnt[gidx_q] != 16'hFFFF)) begin
         grant_cnt[gidx_q] <= grant_cnt[gidx_q] + 16'd1;
      end
   end
`endif

   a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0(grant_q));
   a_valid_match: assert property (@(posedge clk) disable iff (!reset)
      gv_q == (grant_q != '0));
   a_idx_match: assert property (@(posedge clk) disable iff (!reset)
      !gv_q || grant_q[gidx_q]);

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
// Scoreboard bench for wrr_credit_arbiter with NUM_REQ=4: expected grant
// indices are queued as stimulus is applied and compared each cycle.
module tb_wrr_credit_arbiter;
   import arb_pkg::*;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             reset;
   weight_t [N-1:0]  weight;
   logic             weight_load;
`ifdef WRR_CREDIT_ARBITER_STATS_EN
   logic [N-1:0][15:0] grant_cnt;
`endif

   wrr_credit_arbiter_if #(.NUM_REQ(N)) bus ();

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   wrr_credit_arbiter #(
      .NUM_REQ      (N),
      .WEIGHT_W     (4),
      .RESET_WEIGHT (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .weight      (weight),
      .weight_load (weight_load),
`ifdef WRR_CREDIT_ARBITER_STATS_EN
      .grant_cnt   (grant_cnt),
`endif
      .bus         (bus)
   );

   task automatic apply_reset();
      reset       = 1'b0;
      bus.req     = '0;
      bus.ack     = 1'b0;
      weight_load = 1'b0;
      weight      = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
      weight[0]   = weight_t'(w0);
      weight[1]   = weight_t'(w1);
      weight[2]   = weight_t'(w2);
      weight[3]   = weight_t'(w3);
      weight_load = 1'b1;
      @(negedge clk);
      weight_load = 1'b0;
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      bus.req     = '0;
      bus.ack     = 1'b0;
      weight_load = 1'b0;
      weight      = '0;
      #1;
      n_checks++;
      if (bus.grant !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_grant: got %b expected 0000", bus.grant);
      end
      n_checks++;
      if (bus.grant_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b expected 0", bus.grant_valid);
      end
      n_checks++;
      if (bus.grant_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_idx: got %0d expected 0", bus.grant_idx);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.grant_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req_valid: got %b expected 0", bus.grant_valid);
      end
   endtask

   task automatic test_weighted();
      int e;
      logic [N-1:0] eg;
      apply_reset();
      set_weights(3, 1, 2, 0);
      bus.req = 4'b1111;
      bus.ack = 1'b1;
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
         exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(2);
      end
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e  = exp_q.pop_front();
         eg = 4'b0001 << e;
         n_checks++;
         if ({bus.grant_valid, bus.grant_idx, bus.grant} !== {1'b1, 2'(e), eg}) begin
            n_fail++;
            $display("FAIL weighted_seq: got valid=%b idx=%0d grant=%b expected valid=1 idx=%0d grant=%b",
                     bus.grant_valid, bus.grant_idx, bus.grant, e, eg);
         end
      end
      bus.req = '0;
      bus.ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant !== 4'b0000) begin
         n_fail++;
         $display("FAIL weighted_release: got valid=%b grant=%b expected 0/0000",
                  bus.grant_valid, bus.grant);
      end
   endtask

   task automatic test_single();
      int e;
      apply_reset();
      bus.req = 4'b0100;
      bus.ack = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(2);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant !== 4'b0100 || bus.grant_idx !== 2'(e)) begin
            n_fail++;
            $display("FAIL single_req: got valid=%b grant=%b idx=%0d expected valid=1 grant=0100 idx=%0d",
                     bus.grant_valid, bus.grant, bus.grant_idx, e);
         end
      end
      bus.req = '0;
      bus.ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hold();
      int e;
      logic [N-1:0] eg;
      apply_reset();
      set_weights(1, 3, 1, 1);
      bus.req = 4'b0010;
      bus.ack = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back(1);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant !== 4'b0010 || bus.grant_idx !== 2'(e)) begin
            n_fail++;
            $display("FAIL hold_stable: got valid=%b grant=%b idx=%0d expected valid=1 grant=0010 idx=%0d",
                     bus.grant_valid, bus.grant, bus.grant_idx, e);
         end
      end
      n_checks++;
      if (dut.credit[1] !== 4'd3) begin
         n_fail++;
         $display("FAIL hold_credit: got %0d expected 3", dut.credit[1]);
      end
      bus.req = '0;
      @(negedge clk);
      n_checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant !== 4'b0000) begin
         n_fail++;
         $display("FAIL hold_withdraw: got valid=%b grant=%b expected 0/0000",
                  bus.grant_valid, bus.grant);
      end
      n_checks++;
      if (dut.credit[1] !== 4'd3) begin
         n_fail++;
         $display("FAIL withdraw_credit: got %0d expected 3", dut.credit[1]);
      end
      bus.req = 4'b0011;
      bus.ack = 1'b1;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e  = exp_q.pop_front();
         eg = 4'b0001 << e;
         n_checks++;
         if ({bus.grant_valid, bus.grant_idx, bus.grant} !== {1'b1, 2'(e), eg}) begin
            n_fail++;
            $display("FAIL full_weight_seq: got valid=%b idx=%0d grant=%b expected valid=1 idx=%0d grant=%b",
                     bus.grant_valid, bus.grant_idx, bus.grant, e, eg);
         end
      end
      bus.req = '0;
      bus.ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load_ack();
      int e;
      logic [N-1:0] eg;
      apply_reset();
      set_weights(3, 1, 2, 0);
      bus.req = 4'b1111;
      bus.ack = 1'b1;
      exp_q.push_back(0); exp_q.push_back(0);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         n_checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'(e)) begin
            n_fail++;
            $display("FAIL pre_load_seq: got valid=%b idx=%0d expected valid=1 idx=%0d",
                     bus.grant_valid, bus.grant_idx, e);
         end
      end
      set_weights(1, 1, 1, 1);
      n_checks++;
      if (dut.credit !== {4'd1, 4'd1, 4'd1, 4'd1}) begin
         n_fail++;
         $display("FAIL load_credits: got %h expected 1111", dut.credit);
      end
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL load_grant: got valid=%b idx=%0d expected valid=1 idx=0",
                  bus.grant_valid, bus.grant_idx);
      end
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
      exp_q.push_back(0); exp_q.push_back(1);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e  = exp_q.pop_front();
         eg = 4'b0001 << e;
         n_checks++;
         if ({bus.grant_valid, bus.grant_idx, bus.grant} !== {1'b1, 2'(e), eg}) begin
            n_fail++;
            $display("FAIL post_load_seq: got valid=%b idx=%0d grant=%b expected valid=1 idx=%0d grant=%b",
                     bus.grant_valid, bus.grant_idx, bus.grant, e, eg);
         end
      end
      bus.req = '0;
      bus.ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.req = 4'b1111;
      bus.ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL pre_reset_grant: got valid=%b idx=%0d expected valid=1 idx=1",
                  bus.grant_valid, bus.grant_idx);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.grant_valid, bus.grant_idx, bus.grant} !== 7'b0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b idx=%0d grant=%b expected all zero",
                  bus.grant_valid, bus.grant_idx, bus.grant);
      end
      bus.ack = 1'b0;
      bus.req = 4'b1010;
      @(negedge clk);
      reset   = 1'b1;
      bus.ack = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant !== 4'b0010 || bus.grant_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL post_reset_grant: got valid=%b grant=%b idx=%0d expected valid=1 grant=0010 idx=1",
                  bus.grant_valid, bus.grant, bus.grant_idx);
      end
      bus.req = '0;
      bus.ack = 1'b0;
      @(negedge clk);
   endtask

`ifdef WRR_CREDIT_ARBITER_STATS_EN
   task automatic test_stats();
      int exp_cnt[N];
      int c;
      exp_cnt = '{500, 167, 333, 0};
      apply_reset();
      set_weights(3, 1, 2, 0);
      n_checks++;
      if (grant_cnt !== '0) begin
         n_fail++;
         $display("FAIL stats_clear: got %h expected 0", grant_cnt);
      end
      bus.req = 4'b1111;
      bus.ack = 1'b1;
      @(negedge clk);
      repeat (1000) @(negedge clk);
      bus.req = '0;
      bus.ack = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         c = int'(grant_cnt[i]);
         n_checks++;
         if (c < exp_cnt[i] - 3 || c > exp_cnt[i] + 3) begin
            n_fail++;
            $display("FAIL stats_cnt%0d: got %0d expected %0d +/-3", i, c, exp_cnt[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_weighted();
      test_single();
      test_hold();
      test_load_ack();
      test_reset_mid();
`ifdef WRR_CREDIT_ARBITER_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wrr_credit_arbiter.md
Name: wrr_credit_arbiter

Overview:
- Next-generation weighted round-robin arbiter for the vector chip. It replaces the one-cycle, mask-based WRR with a credit-counter design.
- Per-requester credits, a rotating priority pointer, a registered one-hot grant and a grant/ack handshake.
- Sits in front of shared vector-register and memory ports. Each requester receives up to WEIGHT accepted transfers per round and stays work-conserving.

Parameters:
- NUM_REQ, 8, number of requesters (2..32).
- WEIGHT_W, 4, width of each weight and credit counter; maximum weight is 2^WEIGHT_W-1.
- RESET_WEIGHT, 1, value of every weight_q entry after reset (plain round robin).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request vector; a requester holds its bit until acked.
- weight  in  NUM_REQ x WEIGHT_W  per-requester weight, sampled only on weight_load.
- weight_load  in  1  one-cycle pulse that captures weight into weight_q and reloads credits.
- ack  in  1  target accepts the current grant this cycle.
- grant  out  NUM_REQ  registered one-hot grant.
- grant_valid  out  1  a grant is outstanding.
- grant_idx  out  $clog2(NUM_REQ)  binary index of the granted requester.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, grant_idx=0.
  - ptr=0, state=IDLE.
  - weight_q[i]=RESET_WEIGHT, credit[i]=RESET_WEIGHT.
- Definitions:
  - live[i] = req[i] & (weight_q[i]!=0).
  - elig[i] = live[i] & (credit[i]!=0).
  - Weight-0 requesters are never granted.
- Pick:
  - Find the first set bit of the candidate vector, searching from ptr upward with wrap (ptr inclusive).
  - Candidate vector is elig if elig!=0, otherwise live.
- Replenish: if elig==0 and live!=0, load all credit[i]<=weight_q[i] in the same cycle the pick is made. There is no idle bubble (work-conserving).
- State machine:
  - IDLE: if live!=0, register the pick into grant/grant_idx, set grant_valid=1 and go to GRANT. Latency is one cycle from req to grant.
  - GRANT + ack on an accepted transfer:
    - credit[g] decrements by 1.
    - If the new credit[g]!=0, ptr stays at g (burst); otherwise ptr <= g+1 mod NUM_REQ.
    - A new pick is computed from the updated state and registered the same edge, so back-to-back grants are possible (one grant per cycle under a continuous ack).
    - If there is no live request, go to IDLE with grant cleared.
  - GRANT with req[g] dropped and no ack: the grant is withdrawn at the next edge, credit is unchanged, and the block goes to IDLE (or to a new pick if other requesters are live).
  - GRANT with no ack and req[g] held: grant, grant_idx and grant_valid are stable.
- weight_load:
  - weight_q <= weight, and every credit <= new weight; ptr is unchanged.
  - If ack occurs the same cycle, the load wins and the acked decrement is discarded.
  - An outstanding grant whose new weight is 0 is withdrawn next cycle.
- Arithmetic: credits never underflow, because a decrement only occurs on a granted index with credit!=0. Pointer wrap is mod NUM_REQ (non-power-of-2 supported).
- Reset asserted mid-transfer: all state clears asynchronously and the pending transfer is lost.
- Invariants: grant is always one-hot or zero. grant_valid==|grant. grant_idx matches grant when valid.

Optional Feature:
- Macro: WRR_CREDIT_ARBITER_STATS_EN.
- When defined:
  - Adds an output grant_cnt (NUM_REQ x 16), one counter per requester.
  - Each counter increments on accepted transfers, saturates at 0xFFFF and clears on reset or weight_load.
- When undefined: the port and counters are absent, and arbitration behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - localparam defaults for NUM_REQ and WEIGHT_W.
  - typedef weight_t (logic [WEIGHT_W-1:0]).
  - typedef arb_state_e {IDLE, GRANT}.
  - function onehot2idx.
- One combinational sub-module, wrr_rr_picker (vector + ptr -> one-hot + idx). It is reusable by other arbiters.

Test Plan:
- NUM_REQ=4, weights {3,1,2,0}, all req held, ack every cycle -> grant_idx sequence 0,0,0,1,2,2 repeating; idx 3 is never granted.
- After reset, single req[2] with ack tied high -> grant_valid rises one cycle after req, grant=4'b0100 on every cycle; credits replenish with no gap.
- req[1] granted, ack low for 5 cycles, then req[1] drops -> grant stable 5 cycles, cleared the next cycle, credit[1] unchanged; req[1] later gets its full weight.
- Mid-burst on idx 0 (credit 2 remaining), pulse weight_load {1,1,1,1} together with ack -> credits all 1, no decrement applied, next grants 0,1,2,3.
- Assert reset while grant_valid=1 and ack=1 -> all outputs 0 asynchronously; after release, first grant goes to the lowest live index from ptr=0.
- With WRR_CREDIT_ARBITER_STATS_EN defined, run 1000 accepted transfers with weights {3,1,2,0} -> grant_cnt = {500,167,333,0} within ±3.
